// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the asynchronous instruction
// memory address and registers the returned word into the IF/ID stage.
// Handles stall, flush, redirect and halting past the end of memory.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        halted
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // First byte address past the end of instruction memory; 33 bits so the
  // compare cannot wrap even for a full 4 GiB memory.
  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic [31:0] pc_f_plus4;
  logic [31:0] redir_pc_aligned;
  logic        out_of_range;
  logic        load_bubble;
  logic        load_fetch;

  assign pc_f_plus4       = pc_f_q + 32'd4;
  assign redir_pc_aligned = redirect_pc & ~32'h3;
  assign out_of_range     = {1'b0, pc_f_q} >= PC_LIMIT;

  // Next-state selection: PC/state update and what IF/ID loads on this edge.
  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;
    case (state_q)
      S_BOOT: begin
        // Redirect deliberately ignored: nothing downstream is live yet.
        state_d     = S_RUN;
        load_bubble = 1'b1;
      end
      S_HALT: begin
        load_bubble = 1'b1;
        if (redirect) begin
          state_d = S_RUN;
          pc_f_d  = redir_pc_aligned;
        end
      end
      S_RUN: begin
        if (redirect) begin
          pc_f_d      = redir_pc_aligned;
          load_bubble = 1'b1;
        end else if (out_of_range) begin
          state_d     = S_HALT;
          load_bubble = 1'b1;
        end else if (stall_f) begin
          // PC and IF/ID hold; a flush still kills the held instruction.
          load_bubble = flush_d;
        end else begin
          pc_f_d      = pc_f_plus4;
          load_bubble = flush_d;
          load_fetch  = ~flush_d;
        end
      end
      default: begin
        // Unused encoding: recover through BOOT with a bubble.
        state_d     = S_BOOT;
        load_bubble = 1'b1;
      end
    endcase
  end

  // IF/ID next values: bubble is all-zero with valid cleared.
  always_comb begin
    ifid_vld_d   = ifid_vld_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (load_bubble) begin
      ifid_vld_d   = 1'b0;
      ifid_instr_d = 32'h0;
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
    end else if (load_fetch) begin
      ifid_vld_d   = 1'b1;
      ifid_instr_d = imem_instr;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_f_plus4;
    end
  end

  // State, PC and IF/ID registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      pc_f_q       <= RESET_PC & ~32'h3;
      ifid_vld_q   <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      ifid_vld_q   <= ifid_vld_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_addr  = pc_f_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign instr_d    = ifid_instr_q;
  assign valid_d    = ifid_vld_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/flush/
// redirect/reset traffic, all checked against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        stall_f = 1'b0, flush_d = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_d, pc_plus4_d, instr_d;
  logic        valid_d, halted;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall_f(stall_f), .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .instr_d(instr_d), .valid_d(valid_d),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds AAAA0000+i; outside range returns junk.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'd256) return 32'hAAAA_0000 + (addr >> 2);
    return 32'hBAD0_0000;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  // Reference model: fetch mode, PC and the IF/ID contents.
  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc, m_pcd, m_pc4, m_instr;
  logic        m_vld;

  task automatic m_bubble();
    m_vld = 1'b0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0;
  endtask

  task automatic m_reset();
    m_mode = M_BOOT; m_pc = 32'h0; m_bubble();
  endtask

  task automatic m_edge();
    if (m_mode == M_BOOT) begin
      m_bubble(); m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      m_bubble();
      if (redirect) begin m_mode = M_RUN; m_pc = {redirect_pc[31:2], 2'b00}; end
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_bubble();
    end else if (m_pc >= 32'd256) begin
      m_mode = M_HALT; m_bubble();
    end else if (stall_f) begin
      if (flush_d) m_bubble();
    end else begin
      if (flush_d) m_bubble();
      else begin
        m_vld = 1'b1; m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_d", pc_d, m_pcd);
    chk("pc_plus4_d", pc_plus4_d, m_pc4);
    chk("instr_d", instr_d, m_instr);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_vld});
    chk("halted", {31'b0, halted}, {31'b0, (m_mode == M_HALT)});
  endtask

  // One clock edge: update model with the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  // Asynchronous reset pulse in the middle of a cycle (called at edge+1).
  task automatic async_reset();
    #3 reset_n = 1'b0;
    m_reset();
    #1 check_all();
    chk("rst_async_valid", {31'b0, valid_d}, 32'h0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    #12 check_all();
    chk("rst_imem_addr", imem_addr, 32'h0);
    #5 reset_n = 1'b1;

    // Boot sequence
    step(); chk("boot_valid", {31'b0, valid_d}, 32'h0);
    step(); chk("w0_instr", instr_d, 32'hAAAA_0000); chk("w0_pc", pc_d, 32'h0);
    chk("w0_pc4", pc_plus4_d, 32'h4);
    step(); chk("w1_instr", instr_d, 32'hAAAA_0001); chk("w1_pc", pc_d, 32'h4);

    // Stall two edges at pc_f = 8
    stall_f = 1'b1;
    step(); step();
    chk("stall_pc", imem_addr, 32'h8); chk("stall_hold", pc_d, 32'h4);
    stall_f = 1'b0;
    step(); chk("after_stall_pc", pc_d, 32'h8); chk("after_stall_instr", instr_d, 32'hAAAA_0002);

    // Redirect beats stall at pc_f = 12
    chk("pre_redir_pc", imem_addr, 32'hC);
    redirect = 1'b1; redirect_pc = 32'h23; stall_f = 1'b1;
    step(); chk("redir_pcf", imem_addr, 32'h20); chk("redir_bubble", {31'b0, valid_d}, 32'h0);
    idle_inputs();
    step(); chk("redir_pcd", pc_d, 32'h20); chk("redir_valid", {31'b0, valid_d}, 32'h1);

    // Flush alone at pc_f = 16
    redirect = 1'b1; redirect_pc = 32'h10;
    step(); idle_inputs();
    flush_d = 1'b1;
    step(); chk("flush_valid", {31'b0, valid_d}, 32'h0); chk("flush_pcf", imem_addr, 32'h14);
    flush_d = 1'b0;
    step(); chk("post_flush_pc", pc_d, 32'h14);

    // Run to the end of memory
    for (int i = 0; i < 100 && !halted; i++) step();
    chk("reach_halt", {31'b0, halted}, 32'h1);
    chk("halt_pcf", imem_addr, 32'h100);
    for (int i = 0; i < 5; i++) begin
      stall_f = 1'($urandom_range(0, 1)); flush_d = 1'($urandom_range(0, 1));
      step();
      chk("halt_valid", {31'b0, valid_d}, 32'h0);
      chk("halt_held", imem_addr, 32'h100);
    end
    idle_inputs();
    redirect = 1'b1; redirect_pc = 32'h0;
    step(); idle_inputs();
    chk("resume_run", {31'b0, halted}, 32'h0);
    step(); chk("resume_w0", instr_d, 32'hAAAA_0000); chk("resume_valid", {31'b0, valid_d}, 32'h1);

    // Mid-cycle reset at pc_f = 40
    for (int i = 0; i < 20 && imem_addr != 32'd40; i++) step();
    chk("reach_pc40", imem_addr, 32'd40);
    async_reset();
    step(); chk("reboot_valid", {31'b0, valid_d}, 32'h0);
    step(); chk("reboot_w0", instr_d, 32'hAAAA_0000); chk("reboot_pc4", pc_plus4_d, 32'h4);
    step(); chk("reboot_w1", instr_d, 32'hAAAA_0001);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      stall_f     = ($urandom_range(0, 9) < 3);
      flush_d     = ($urandom_range(0, 9) < 2);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom_range(0, 300);
      if ($urandom_range(0, 149) == 0) begin
        idle_inputs();
        async_reset();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
